// File: rtl/fir_engine.sv
// fir_engine: time-shared multi-bank FIR MAC engine.
//
// One sample per start request is written into a circular history buffer,
// then TAPS multiply-accumulate steps are run serially against the
// coefficient bank selected at start. The rounded, DC-restored and
// saturated result is presented on result together with a one-cycle done.
// The coefficient RAM is writable at any time, except that the bank in use
// is protected for the duration of a computation.
//
// Ports:
//   clk, rstn      clock (rising edge) / asynchronous active-low reset
//   start, val     sample request and offset-binary sample
//   bank_sel       coefficient bank, latched at start
//   dc_en          remove DC_OFFSET before MAC and restore it after
//   bypass         result = val (sample is still stored in history)
//   flush          clear the history fill count while idle
//   coef_we/coef_bank/coef_addr/coef_wdata   coefficient write port
//   result, done   filtered output (held) and its one-cycle valid strobe
//   busy           computation in progress
//   overrun        start rejected because a computation was in flight
//   coef_err       coefficient write to the bank in use was dropped
module fir_engine #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 24,
  parameter int COEF_FRAC = 16,
  parameter int TAPS      = 211,
  parameter int NBANKS    = 4,
  parameter int DC_OFFSET = 32768
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [DATA_W-1:0]          val,
  input  logic [$clog2(NBANKS)-1:0]  bank_sel,
  input  logic                       dc_en,
  input  logic                       bypass,
  input  logic                       flush,
  input  logic                       coef_we,
  input  logic [$clog2(NBANKS)-1:0]  coef_bank,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]          coef_wdata,
  output logic [DATA_W-1:0]          result,
  output logic                       done,
  output logic                       busy,
  output logic                       overrun,
  output logic                       coef_err
);

  localparam int AW     = $clog2(TAPS);
  localparam int BW     = $clog2(NBANKS);
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam int X_W    = DATA_W + 1;
  localparam int PROD_W = X_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);

  localparam logic signed [X_W-1:0] DC_X   = X_W'(DC_OFFSET);
  localparam logic signed [ACC_W:0] RND_K  = (ACC_W+1)'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [ACC_W:0] DC_K   = (ACC_W+1)'(DC_OFFSET);
  localparam logic signed [ACC_W:0] MAX_K  = (ACC_W+1)'((64'd1 << DATA_W) - 64'd1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_MAC, S_DRAIN, S_OUT} state_t;

  // Sample to signed MAC operand; taps beyond the filled history read as 0.
  function automatic logic signed [X_W-1:0] to_operand(input logic [DATA_W-1:0] s,
                                                       input logic dc,
                                                       input logic keep);
    logic signed [X_W-1:0] x;
    x = signed'({1'b0, s});
    if (dc) x = x - DC_X;
    if (!keep) x = '0;
    return x;
  endfunction

  // Round half up, drop fraction, restore DC, clamp to the unsigned range.
  function automatic logic [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] sum,
                                                  input logic dc);
    logic signed [ACC_W:0] t;
    t = {sum[ACC_W-1], sum};
    t = t + RND_K;
    t = t >>> COEF_FRAC;
    if (dc) t = t + DC_K;
    if (t < 0) return '0;
    if (t > MAX_K) return '1;
    return t[DATA_W-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         samp_q;
  logic [BW-1:0]             bank_q;
  logic                      dc_q, byp_q;
  logic [AW-1:0]             wptr_q;
  logic [CNT_W-1:0]          fill_q;
  logic                      drn_q;

  logic [DATA_W-1:0]         hist_mem [TAPS];
  logic signed [COEF_W-1:0]  coef_mem [NBANKS][TAPS];

  logic [AW-1:0]             tap_p0, ridx_p0;
  logic signed [X_W-1:0]     x_p1;
  logic signed [COEF_W-1:0]  c_p1;
  logic                      vld_p1;
  logic signed [PROD_W-1:0]  prod_p2;
  logic                      vld_p2;
  logic signed [ACC_W-1:0]   acc_q;

  logic [DATA_W-1:0]         result_q;
  logic                      done_q, overrun_q, coef_err_q;

  logic                      accept, in_flight, coef_block, fin;
  logic signed [ACC_W-1:0]   sum_fin;

  // A new request is taken in IDLE and also in OUT, so back-to-back
  // samples lose no cycle.
  assign accept     = start && (state_q == S_IDLE || state_q == S_OUT);
  assign in_flight  = (state_q == S_WRITE) || (state_q == S_MAC) || (state_q == S_DRAIN);
  assign coef_block = in_flight && (coef_bank == bank_q);
  // Final product is still in flight in the second drain cycle; fold it in
  // directly instead of waiting for one more accumulate.
  assign sum_fin    = acc_q + ACC_W'(prod_p2);
  assign fin        = (state_q == S_DRAIN && drn_q) || (state_q == S_OUT && byp_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_WRITE;
      S_WRITE: state_d = byp_q ? S_OUT : S_MAC;
      S_MAC:   if (tap_p0 == AW'(TAPS - 1)) state_d = S_DRAIN;
      S_DRAIN: if (drn_q) state_d = S_OUT;
      S_OUT:   state_d = start ? S_WRITE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      bank_q     <= '0;
      dc_q       <= 1'b0;
      byp_q      <= 1'b0;
      wptr_q     <= '0;
      fill_q     <= '0;
      drn_q      <= 1'b0;
      tap_p0     <= '0;
      ridx_p0    <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= fin;
      overrun_q  <= start && in_flight;
      coef_err_q <= coef_we && coef_block;
      if (fin) result_q <= byp_q ? samp_q : round_sat(sum_fin, dc_q);
      if (accept) begin
        bank_q <= bank_sel;
        dc_q   <= dc_en;
        byp_q  <= bypass;
      end else if (state_q == S_IDLE && flush) begin
        fill_q <= '0;
      end
      if (state_q == S_WRITE) begin
        wptr_q  <= (wptr_q == AW'(TAPS - 1)) ? '0 : wptr_q + 1'b1;
        if (fill_q != CNT_W'(TAPS)) fill_q <= fill_q + 1'b1;
        tap_p0  <= '0;
        ridx_p0 <= wptr_q;
        drn_q   <= 1'b0;
      end
      if (state_q == S_MAC) begin
        tap_p0  <= tap_p0 + 1'b1;
        ridx_p0 <= (ridx_p0 == '0) ? AW'(TAPS - 1) : ridx_p0 - 1'b1;
      end
      if (state_q == S_DRAIN) drn_q <= 1'b1;
      vld_p1 <= (state_q == S_MAC);
      vld_p2 <= vld_p1;
    end
  end

  // Data path storage: no reset, contents are qualified by control state.
  always_ff @(posedge clk) begin
    if (accept) samp_q <= val;
    if (state_q == S_WRITE) hist_mem[wptr_q] <= samp_q;
    if (coef_we && !coef_block && int'(coef_addr) < TAPS && int'(coef_bank) < NBANKS)
      coef_mem[coef_bank][coef_addr] <= signed'(coef_wdata);
  end

  // p0 -> p1: history and coefficient read, operand formation
  always_ff @(posedge clk) begin
    x_p1 <= to_operand(hist_mem[ridx_p0], dc_q, int'(tap_p0) < int'(fill_q));
    c_p1 <= coef_mem[bank_q][tap_p0];
  end

  // p1 -> p2: multiply
  always_ff @(posedge clk) begin
    prod_p2 <= PROD_W'(x_p1) * PROD_W'(c_p1);
  end

  // p2 -> accumulator
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE) acc_q <= '0;
    else if (vld_p2)        acc_q <= acc_q + ACC_W'(prod_p2);
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = (state_q == S_MAC) || (state_q == S_DRAIN) || (state_q == S_OUT && byp_q);
  assign overrun  = overrun_q;
  assign coef_err = coef_err_q;

endmodule

// File: doc/fir_engine.md
Name: fir_engine

Overview:
- Parametrised successor to the fixed three-instance LPF/HPF/BPF filter wrapper: one time-shared, multi-bank FIR MAC engine with an integrated sample ring buffer and a writable coefficient RAM.
- Sits between the XADC sample path and the oscilloscope capture logic.
- Per sample: accepts a start/val pulse, computes one filtered output with the selected coefficient bank, and returns result with a one-cycle done.

Parameters:
- DATA_W, 16, sample/result width (unsigned offset-binary)
- COEF_W, 24, coefficient width (signed two's complement)
- COEF_FRAC, 16, fractional bits of coefficients
- TAPS, 211, filter length (>=2)
- NBANKS, 4, number of coefficient banks
- DC_OFFSET, 32768, midscale removed/restored when dc_en=1

Ports:
- clk in 1: clock, all logic on rising edge
- rstn in 1: asynchronous active-low reset
- start in 1: one-cycle request, sample on val
- val in DATA_W: input sample
- bank_sel in clog2(NBANKS): coefficient bank, latched at start
- dc_en in 1: DC removal/restore, latched at start
- bypass in 1: result=val, latched at start
- flush in 1: clears history fill count (idle only)
- coef_we in 1: coefficient write strobe
- coef_bank in clog2(NBANKS): write bank
- coef_addr in clog2(TAPS): write tap index
- coef_wdata in COEF_W: coefficient value
- result out DATA_W: last filtered output, held until next done
- done out 1: one-cycle pulse, result valid
- busy out 1: high from the cycle after start accept until done
- overrun out 1: one-cycle pulse, start rejected while busy
- coef_err out 1: one-cycle pulse, write to active bank rejected

Behaviour:
- Reset (async, rstn=0): result=0, done=0, busy=0, overrun=0, coef_err=0, state IDLE, write pointer=0, fill count=0. Coefficient RAM is not cleared.
- Reset mid-computation aborts immediately. No done is produced.
- FSM states: IDLE, WRITE, MAC, DRAIN, OUT.
  - IDLE: start=1 latches val/bank_sel/dc_en/bypass and goes to WRITE.
  - WRITE (1 cycle): stores sample at write pointer; pointer wraps TAPS-1 -> 0; fill count saturates at TAPS. Next state is OUT if bypass, else MAC.
  - MAC (exactly TAPS cycles): issues reads for k=0..TAPS-1.
  - DRAIN (2 cycles): RAM read + multiply pipeline flush.
  - OUT (1 cycle): result and done registered, then IDLE.
- Latency from the start-sampling edge E0:
  - filter mode: done high E(TAPS+3) -> E(TAPS+4)
  - bypass: done high E2 -> E3
- Start back-to-back: next start is accepted the cycle done is high (OUT -> accepts as IDLE would, going straight to WRITE).
- Start during WRITE/MAC/DRAIN: ignored; overrun pulses the next cycle; the computation in progress is unaffected.
- Filter equation: y = sum c[bank][k] * x[n-k], k=0..TAPS-1, where x[n] is the newest sample.
  - Taps with k >= fill count contribute 0 (no stale RAM data).
- Operand: x = sample - DC_OFFSET when dc_en, else x = sample. Signed, DATA_W+1 bits.
- Accumulator: signed, DATA_W+1+COEF_W+clog2(TAPS) bits; no internal overflow is possible.
- Output computation:
  - acc + 2^(COEF_FRAC-1), arithmetic shift right by COEF_FRAC (round half up)
  - + DC_OFFSET if dc_en
  - saturate to [0, 2^DATA_W-1]
- Bypass: result = val unchanged. The sample is still written to history.
- Coefficient writes:
  - Accepted any cycle, take effect on the next edge.
  - While busy, a write with coef_bank equal to the latched bank is dropped and coef_err pulses.
  - Writes to other banks proceed.
- flush: honoured only in IDLE, and loses to a simultaneous start (start wins, flush ignored). Sets fill count=0; the pointer is unchanged.

Test Plan:
- TAPS=4, COEF_FRAC=16, bank0 all 0x004000 (0.25), dc_en=0. Start with 100, 200, 300, 400, 500 -> results 25, 75, 150, 250, 350; done exactly 7 cycles after each start edge; busy high 6 cycles.
- Bank1 c0=0x020000 (2.0), others 0, dc_en=0, val=40000 -> result 65535 (saturate high). Bank1 c0=0xFF0000 (-1.0), val=100 -> result 0 (saturate low).
- dc_en=1, bank2 c0=0xFF0000, others 0, val=33768 -> result 31768.
- Pulse start again 3 cycles after the first start -> overrun pulse, single done, first result correct. During that busy period, a coef_we to the active bank -> coef_err; a write to another bank succeeds, checked by a later computation.
- bypass=1, val=1234 -> result 1234 with done 2 cycles after start. Then bypass=0 with moving-average bank -> history includes 1234.
- Assert rstn low during MAC -> outputs 0 immediately, no done. After release, start 100 with bank0 -> result 25 (fill reset, coefficients retained). Flush then start 400 -> result 100.
